draw_line_arbiter: RTL and testbench

Round-robin arbiter that shares one `draw_line` engine between `NREQ` independent drawing requesters (e.g. several `render_*` sequencers). Each requester submits one line command (endpoints plus colour index) over a valid/ready handshake. The arbiter latches the winning command, starts the engine, waits for the engine's `done`, then returns a one-cycle completion pulse to that requester. It sits between the render sequencers and the single `draw_line` instance that feeds the framebuffer.

---
 rtl/draw_line_arbiter_pkg.sv | 21 ++
 rtl/draw_line_arbiter_rr_pick.sv | 52 +++++
 rtl/draw_line_arbiter.sv | 120 ++++++++++++
 tb/tb_draw_line_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_line_arbiter_pkg.sv
// Shared types and defaults for the draw_line arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   NREQ_DEFAULT - default number of requesters sharing one draw_line engine
//   arb_state_e  - arbiter control states
package draw_arb_pkg;

    localparam int NREQ_DEFAULT = 4;

    // IDLE : waiting for a request, req_ready may be driven
    // START: one-cycle engine start pulse is on the output
    // BUSY : engine is drawing, waiting for its done pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/draw_line_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports:
//   req [NREQ]   in  request vector
//   ptr          in  index with highest priority this cycle
//   any          out at least one request bit set
//   idx          out winning index (0 when any=0)
//   sel [NREQ]   out one-hot of idx (zero when any=0)
module rr_pick
    import draw_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic                    any,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic [NREQ-1:0]         sel
);

    localparam int PTRW = $clog2(NREQ);

    logic [NREQ-1:0]   hi_mask;
    logic [2*NREQ-1:0] dbl;

    // Lower copy keeps only requests at or above ptr; the upper copy is the
    // unmasked vector, so a plain lowest-bit-first search of the doubled
    // vector yields the wrap-around winner.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        dbl = {req, req & hi_mask};

        any = |req;
        idx = '0;
        // Descending scan so the lowest set position is the last assignment.
        for (int i = 2*NREQ-1; i >= 0; i--) begin
            if (dbl[i]) begin
                idx = PTRW'(i % NREQ);
            end
        end

        sel = '0;
        if (any) begin
            sel[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/draw_line_arbiter.sv
// Round-robin arbiter sharing one draw_line engine among NREQ requesters.
// Latency: accept at T, line_start at T+1, req_done the cycle after line_done.
// Backpressure: req_ready only in IDLE, one-hot to the winner; others wait.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   req_valid/req_ready       per-requester command handshake (ready combinational)
//   req_x0/y0/x1/y1/req_cidx  packed per-requester command fields
//   req_done                  one-hot one-cycle completion pulse to the owner
//   line_start, x0..y1, cidx  latched command and start pulse to the engine
//   line_done                 engine completion pulse (ignored outside BUSY)
//   busy                      acceptance until (exclusive) the req_done cycle
//   grant                     index of current or last owner
module draw_line_arbiter
    import draw_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEFAULT,
    parameter int CORDW = 16,
    parameter int CIDXW = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*CORDW-1:0]   req_x0,
    input  logic [NREQ*CORDW-1:0]   req_y0,
    input  logic [NREQ*CORDW-1:0]   req_x1,
    input  logic [NREQ*CORDW-1:0]   req_y1,
    input  logic [NREQ*CIDXW-1:0]   req_cidx,
    output logic [NREQ-1:0]         req_done,
    output logic                    line_start,
    output logic [CORDW-1:0]        x0,
    output logic [CORDW-1:0]        y0,
    output logic [CORDW-1:0]        x1,
    output logic [CORDW-1:0]        y1,
    output logic [CIDXW-1:0]        cidx,
    input  logic                    line_done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant
);

    localparam int PTRW = $clog2(NREQ);

    arb_state_e      state;
    logic [PTRW-1:0] rr_ptr;

    logic            pick_any;
    logic [PTRW-1:0] pick_idx;
    logic [NREQ-1:0] pick_sel;

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .any  (pick_any),
        .idx  (pick_idx),
        .sel  (pick_sel)
    );

    // Held low during reset so a requester never sees a handshake that the
    // registers below are about to ignore.
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && !rst) begin
            req_ready = pick_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            x0         <= '0;
            y0         <= '0;
            x1         <= '0;
            y1         <= '0;
            cidx       <= '0;
            line_start <= 1'b0;
            req_done   <= '0;
            busy       <= 1'b0;
        end else begin
            line_start <= 1'b0;
            req_done   <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant      <= pick_idx;
                        x0         <= req_x0[pick_idx*CORDW +: CORDW];
                        y0         <= req_y0[pick_idx*CORDW +: CORDW];
                        x1         <= req_x1[pick_idx*CORDW +: CORDW];
                        y1         <= req_y1[pick_idx*CORDW +: CORDW];
                        cidx       <= req_cidx[pick_idx*CIDXW +: CIDXW];
                        line_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    // Engine cannot finish in its start cycle; any done here
                    // is stale and deliberately dropped.
                    state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (line_done) begin
                        req_done[grant] <= 1'b1;
                        rr_ptr          <= (grant == PTRW'(NREQ-1)) ? '0 : grant + 1'b1;
                        busy            <= 1'b0;
                        state           <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_line_arbiter.sv
// Testbench for draw_line_arbiter: directed scenarios followed by random
// rounds, with grants predicted by a simple rotating-priority reference.
module tb_draw_line_arbiter;

    localparam int NREQ  = 4;
    localparam int CORDW = 16;
    localparam int CIDXW = 4;
    localparam int GW    = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*CORDW-1:0] req_x0, req_y0, req_x1, req_y1;
    logic [NREQ*CIDXW-1:0] req_cidx;
    logic [NREQ-1:0]       req_done;
    logic                  line_start;
    logic [CORDW-1:0]      x0, y0, x1, y1;
    logic [CIDXW-1:0]      cidx;
    logic                  line_done;
    logic                  busy;
    logic [GW-1:0]         grant;

    logic [CORDW-1:0] cx0 [NREQ];
    logic [CORDW-1:0] cy0 [NREQ];
    logic [CORDW-1:0] cx1 [NREQ];
    logic [CORDW-1:0] cy1 [NREQ];
    logic [CIDXW-1:0] ccidx [NREQ];

    int n_vec = 0;
    int n_err = 0;
    int mptr  = 0;   // reference round-robin pointer

    always #5 clk = ~clk;

    always_comb begin
        req_x0   = '0;
        req_y0   = '0;
        req_x1   = '0;
        req_y1   = '0;
        req_cidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_x0[i*CORDW +: CORDW]   = cx0[i];
            req_y0[i*CORDW +: CORDW]   = cy0[i];
            req_x1[i*CORDW +: CORDW]   = cx1[i];
            req_y1[i*CORDW +: CORDW]   = cy1[i];
            req_cidx[i*CIDXW +: CIDXW] = ccidx[i];
        end
    end

    draw_line_arbiter #(
        .NREQ  (NREQ),
        .CORDW (CORDW),
        .CIDXW (CIDXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x0     (req_x0),
        .req_y0     (req_y0),
        .req_x1     (req_x1),
        .req_y1     (req_y1),
        .req_cidx   (req_cidx),
        .req_done   (req_done),
        .line_start (line_start),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .cidx       (cidx),
        .line_done  (line_done),
        .busy       (busy),
        .grant      (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // First valid requester at or after p, scanning upward with wrap.
    function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_cmd(input int i, input int ax0, input int ay0,
                           input int ax1, input int ay1, input int c);
        cx0[i]   = CORDW'(ax0);
        cy0[i]   = CORDW'(ay0);
        cx1[i]   = CORDW'(ax1);
        cy1[i]   = CORDW'(ay1);
        ccidx[i] = CIDXW'(c);
    endtask

    task automatic rand_cmd(input int i);
        cx0[i]   = CORDW'($urandom);
        cy0[i]   = CORDW'($urandom);
        cx1[i]   = CORDW'($urandom);
        cy1[i]   = CORDW'($urandom);
        ccidx[i] = CIDXW'($urandom);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
        chk({tag, "_req_done"},   32'(req_done),   32'd0);
        chk({tag, "_line_start"}, 32'(line_start), 32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_grant"},      32'(grant),      32'd0);
        chk({tag, "_x0"},         32'(x0),         32'd0);
        chk({tag, "_y0"},         32'(y0),         32'd0);
        chk({tag, "_x1"},         32'(x1),         32'd0);
        chk({tag, "_y1"},         32'(y1),         32'd0);
        chk({tag, "_cidx"},       32'(cidx),       32'd0);
    endtask

    // Reset with the given request mask already raised; leaves the bench
    // just after the first clock edge out of reset.
    task automatic do_reset(input logic [NREQ-1:0] v);
        rst       = 1'b1;
        line_done = 1'b0;
        req_valid = v;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        mptr = 0;
    endtask

    // One full command: wait for the handshake, act as the engine finishing
    // k cycles after acceptance, and check the completion pulse. Returns at
    // the sampling point of the req_done cycle.
    task automatic run_cmd(input int k, input bit keep, input bit spur,
                           input int want, output int waited);
        int g;
        logic [CORDW-1:0] ex0, ey0, ex1, ey1;
        logic [CIDXW-1:0] ec;
        #1;
        waited = 0;
        while (!(|req_ready) && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        g = model_pick(req_valid, mptr);
        if (g < 0) g = 0;
        chk("ready_onehot", 32'(req_ready), 32'd1 << g);
        ex0 = cx0[g]; ey0 = cy0[g]; ex1 = cx1[g]; ey1 = cy1[g]; ec = ccidx[g];

        @(posedge clk);
        #1;                                   // T+1, START
        if (keep) rand_cmd(g);
        else      req_valid[g] = 1'b0;
        line_done = spur;
        @(negedge clk);
        chk("line_start", 32'(line_start), 32'd1);
        chk("grant", 32'(grant), 32'(g));
        if (want >= 0) chk("plan_grant", 32'(grant), 32'(want));
        chk("x0", 32'(x0), 32'(ex0));
        chk("y0", 32'(y0), 32'(ey0));
        chk("x1", 32'(x1), 32'(ex1));
        chk("y1", 32'(y1), 32'(ey1));
        chk("cidx", 32'(cidx), 32'(ec));
        chk("busy_start", 32'(busy), 32'd1);
        chk("ready_start", 32'(req_ready), 32'd0);

        for (int c = 2; c <= k; c++) begin
            @(posedge clk);
            #1;
            line_done = (c == k);
            @(negedge clk);
            chk("busy_wait", 32'(busy), 32'd1);
            chk("done_early", 32'(req_done), 32'd0);
            chk("start_once", 32'(line_start), 32'd0);
            chk("ready_busy", 32'(req_ready), 32'd0);
        end

        @(posedge clk);
        #1;                                   // T+k+1
        line_done = 1'b0;
        @(negedge clk);
        chk("req_done", 32'(req_done), 32'd1 << g);
        chk("busy_end", 32'(busy), 32'd0);
        mptr = (g + 1) % NREQ;
    endtask

    initial begin
        int w;
        for (int i = 0; i < NREQ; i++) set_cmd(i, 0, 0, 0, 0, 0);
        line_done = 1'b0;

        // Single request from requester 2, engine done six cycles after accept.
        do_reset('0);
        set_cmd(2, 10, 20, 30, 40, 5);
        req_valid = 4'b0100;
        run_cmd(6, 1'b0, 1'b0, 2, w);

        // Requesters 0 and 3 valid out of reset, then 0 and 1 re-raised.
        set_cmd(0, 1, 2, 3, 4, 6);
        set_cmd(3, -5, -6, 7, 8, 9);
        do_reset(4'b1001);
        run_cmd(3, 1'b0, 1'b0, 0, w);
        run_cmd(2, 1'b0, 1'b0, 3, w);
        rand_cmd(0);
        rand_cmd(1);
        req_valid = 4'b0011;
        run_cmd(3, 1'b0, 1'b0, -1, w);
        run_cmd(2, 1'b0, 1'b0, -1, w);

        // Fairness: everyone requesting continuously for 12 commands.
        for (int i = 0; i < NREQ; i++) rand_cmd(i);
        do_reset(4'b1111);
        for (int i = 0; i < 12; i++) begin
            run_cmd(int'($urandom_range(2, 5)), 1'b1, 1'b0, i % NREQ, w);
            if (i > 0) chk("fair_b2b_wait", 32'(w), 32'd0);
        end
        req_valid = '0;

        // Requester 1 keeps a second command ready behind its first.
        rand_cmd(1);
        req_valid = 4'b0010;
        run_cmd(3, 1'b1, 1'b0, 1, w);
        run_cmd(2, 1'b0, 1'b0, 1, w);
        chk("b2b_wait", 32'(w), 32'd0);

        // Stray line_done while IDLE, then while in START.
        @(posedge clk);
        #1 line_done = 1'b1;
        @(negedge clk);
        chk("idle_spur_done", 32'(req_done), 32'd0);
        chk("idle_spur_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 line_done = 1'b0;
        @(negedge clk);
        chk("idle_spur_done2", 32'(req_done), 32'd0);
        chk("idle_spur_start", 32'(line_start), 32'd0);
        rand_cmd(0);
        req_valid = 4'b0001;
        run_cmd(4, 1'b0, 1'b1, 0, w);

        // Reset two cycles after line_start while BUSY.
        rand_cmd(1);
        req_valid = 4'b0010;
        run_cmd(2, 1'b0, 1'b0, 1, w);       // pointer now past 1
        rand_cmd(1);
        rand_cmd(2);
        rand_cmd(3);
        req_valid = 4'b1110;
        #1;
        chk("rst_pre_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1 req_valid[2] = 1'b0;             // T+1
        @(negedge clk);
        chk("rst_pre_start", 32'(line_start), 32'd1);
        @(posedge clk);                     // T+2
        @(posedge clk);
        #1 rst = 1'b1;                      // T+3
        @(posedge clk);                     // T+4
        @(negedge clk);
        chk_zero("midbusy");
        @(posedge clk);
        #1 rst = 1'b0;                      // T+5
        mptr = 0;
        @(negedge clk);
        chk("rst_no_done", 32'(req_done), 32'd0);
        run_cmd(3, 1'b0, 1'b0, 1, w);

        // Random rounds: requests appear and commands vary.
        req_valid = '0;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    rand_cmd(i);
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                rand_cmd(r % NREQ);
                req_valid[r % NREQ] = 1'b1;
            end
            run_cmd(int'($urandom_range(2, 6)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
